axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 responder (slave) closing the io_master side of the core's memory arbiter: a 32-bit word SRAM model, synthesizable and usable as the NPC simulation memory.
- Accepts single and burst reads/writes (FIXED/INCR) and returns R/B responses with configurable read latency and echoed IDs.
- One transaction in flight at a time. Reads and writes are serialized through one FSM.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array.
- BASE, 32'h8000_0000, byte base address of the window.
- RD_LAT, 2, cycles from AR handshake to first rvalid (≥1).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- awready  out  1; awvalid  in  1; awaddr  in  32; awid  in  4; awlen  in  8; awsize  in  3; awburst  in  2.
- wready  out  1; wvalid  in  1; wdata  in  32; wstrb  in  4; wlast  in  1.
- bready  in  1; bvalid  out  1; bresp  out  2; bid  out  4.
- arready  out  1; arvalid  in  1; araddr  in  32; arid  in  4; arlen  in  8; arsize  in  3; arburst  in  2.
- rready  in  1; rvalid  out  1; rresp  out  2; rdata  out  32; rlast  out  1; rid  out  4.

Behaviour:
- Reset: async, all state registers cleared.
  - While rst is high: awready, arready, wready, bvalid and rvalid are 0; bresp, bid, rresp, rdata, rlast and rid are 0.
  - FSM goes to IDLE. Array contents are not reset.
  - If reset occurs mid-burst, the burst is abandoned with no response.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - arready = awready = 1 (combinational from state, gated by rst).
  - If arvalid and awvalid are high in the same cycle, read wins and awready is forced to 0 that cycle.
  - AR handshake: latch addr, id, len, size, burst; load latency counter with RD_LAT-1; go to RD_WAIT.
  - AW handshake: latch the same fields; go to WR_DATA.
- RD_WAIT: counter decrements each cycle. At 0, go to RD_DATA.
- RD_DATA:
  - rvalid = 1, rid = latched id, rdata = word at current address.
  - rlast = 1 on beat index == len.
  - rdata/rresp/rlast are held stable while rvalid && !rready.
  - On each handshake, advance the address and beat counter. After the last beat, go to IDLE; arready returns the next cycle.
- WR_DATA:
  - wready = 1. Each handshake writes the bytes whose wstrb bit is set.
  - Burst ends on beat index == len, regardless of wlast.
  - If wlast disagrees with the expected last beat, set a sticky error flag.
  - After the last beat, go to WR_RESP.
- WR_RESP:
  - bvalid = 1, bid = latched id, bresp = OKAY, or SLVERR if the error flag is set.
  - Held until bready; then go to IDLE and clear the flag.
- Address update per beat:
  - INCR: addr += (1 << size).
  - FIXED: addr unchanged.
  - WRAP (2'b10) and reserved (2'b11): treated as INCR.
- Address decode: word index = (addr - BASE) >> 2.
  - Out of range (addr < BASE or index ≥ DEPTH): that beat's write is discarded, read rdata = 0, rresp = DECERR (2'b11).
  - A write burst with any out-of-range beat returns bresp DECERR (DECERR takes priority over SLVERR).
- Sub-word sizes: a full aligned word is returned; the master selects bytes. Writes rely solely on wstrb.
- Beat counter is 8 bits; len = 255 gives 256 beats with no overflow past the last beat.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings FIXED/INCR/WRAP.
  - Response encodings OKAY/EXOKAY/SLVERR/DECERR.
  - FSM state typedef.
  - Width constants: ID 4, ADDR 32, DATA 32, LEN 8.
- One sub-module: axi_sram_array. It holds DEPTH×32 storage with byte-write enables and a combinational read port, and keeps the FSM separate from the storage.

Test Plan:
- Single write, then read:
  - AW addr 0x8000_0010, id 3, len 0; W 0xDEADBEEF, strb 0xF, wlast 1 → B OKAY, bid 3.
  - AR to the same address, id 5 → after RD_LAT=2 cycles, rdata 0xDEADBEEF, rresp 0, rlast 1, rid 5.
- INCR burst with backpressure:
  - Write 4 beats 0x11..0x44 at 0x8000_0100.
  - Read back with len 3 while toggling rready every cycle → beats in order 0x11, 0x22, 0x33, 0x44; rlast only on 4th; data held while stalled.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with strb 0x5 → readback 0xFF00FF00.
- Simultaneous AR/AW in IDLE:
  - Read completes first; awready is 0 that cycle.
  - Write is then accepted and bresp is OKAY.
- Error responses:
  - AR at 0x7FFF_FFFC → rresp DECERR, rdata 0.
  - Write len 1 with wlast on beat 0 → 2 beats accepted, bresp SLVERR.
- Reset mid-burst:
  - Assert rst during beat 2 of an 8-beat read → rvalid drops immediately (async).
  - After release, arready = 1 and a new read works normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, widths, FSM state codes and burst address helper.
package axi_pkg;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_WAIT = 3'd1;
  localparam state_t ST_RD_DATA = 3'd2;
  localparam state_t ST_WR_DATA = 3'd3;
  localparam state_t ST_WR_RESP = 3'd4;

  // WRAP and reserved encodings advance like INCR
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0] burst,
                                                  input logic [2:0] size);
    return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
  endfunction
endpackage

// File: rtl/axi_sram_array.sv
// Word SRAM with per-byte write enables; write on the clock edge, read is combinational.
// Contents are intentionally never reset.
import axi_pkg::*;

module axi_sram_array #(
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IW-1:0]       idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM responder: one transaction at a time, first read beat RD_LAT cycles after AR,
// R/B held until rready/bready; reads win over writes when both arrive together in IDLE.
import axi_pkg::*;

module axi_sram_slave #(
  parameter int          DEPTH  = 4096,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic [3:0]  rid
);
  localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAT_INIT = 8'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ID_W-1:0]   id;
  logic [LEN_W-1:0]  len, beat, lat_cnt;
  logic [2:0]        size;
  logic [1:0]        burst;
  logic              wr_err, wr_dec;

  logic [31:0]       word;
  logic              in_range, last_beat;
  logic              ar_hs, aw_hs, w_hs, r_hs;
  logic [DATA_W-1:0] mem_rdata;

  assign word      = (addr - BASE) >> 2;
  assign in_range  = (addr >= BASE) && (word < 32'(DEPTH));
  assign last_beat = (beat == len);

  assign arready = !rst && (state == ST_IDLE);
  assign awready = arready && !arvalid;
  assign wready  = !rst && (state == ST_WR_DATA);
  assign rvalid  = !rst && (state == ST_RD_DATA);
  assign bvalid  = !rst && (state == ST_WR_RESP);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign r_hs  = rvalid && rready;

  // Address and beat only move on a handshake, so R fields stay stable under stall
  assign rid   = rvalid ? id : '0;
  assign rdata = (rvalid && in_range) ? mem_rdata : '0;
  assign rresp = (rvalid && !in_range) ? RESP_DECERR : RESP_OKAY;
  assign rlast = rvalid && last_beat;
  assign bid   = bvalid ? id : '0;
  assign bresp = !bvalid ? RESP_OKAY :
                 wr_dec  ? RESP_DECERR :
                 wr_err  ? RESP_SLVERR : RESP_OKAY;

  axi_sram_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk),
    .we    (w_hs && in_range),
    .be    (wstrb),
    .idx   (word[IW-1:0]),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      id      <= '0;
      len     <= '0;
      beat    <= '0;
      lat_cnt <= '0;
      size    <= '0;
      burst   <= '0;
      wr_err  <= 1'b0;
      wr_dec  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            addr    <= araddr;
            id      <= arid;
            len     <= arlen;
            size    <= arsize;
            burst   <= arburst;
            beat    <= '0;
            lat_cnt <= LAT_INIT;
            state   <= ST_RD_WAIT;
          end else if (aw_hs) begin
            addr   <= awaddr;
            id     <= awid;
            len    <= awlen;
            size   <= awsize;
            burst  <= awburst;
            beat   <= '0;
            wr_err <= 1'b0;
            wr_dec <= 1'b0;
            state  <= ST_WR_DATA;
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == '0) state <= ST_RD_DATA;
          else lat_cnt <= lat_cnt - 8'd1;
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            if (last_beat) state <= ST_IDLE;
            else begin
              addr <= next_addr(addr, burst, size);
              beat <= beat + 8'd1;
            end
          end
        end
        ST_WR_DATA: begin
          if (w_hs) begin
            if (wlast != last_beat) wr_err <= 1'b1;
            if (!in_range) wr_dec <= 1'b1;
            if (last_beat) state <= ST_WR_RESP;
            else begin
              addr <= next_addr(addr, burst, size);
              beat <= beat + 8'd1;
            end
          end
        end
        ST_WR_RESP: begin
          if (bready) begin
            state  <= ST_IDLE;
            wr_err <= 1'b0;
            wr_dec <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench: stimulus pushes expected R/B responses, a negedge monitor pops and compares.
import axi_pkg::*;

module tb_axi_sram_slave;
  localparam int RD_LAT = 2;

  logic        clk = 0, rst = 1;
  logic        awready, awvalid = 0; logic [31:0] awaddr = 0; logic [3:0] awid = 0;
  logic [7:0]  awlen = 0; logic [2:0] awsize = 0; logic [1:0] awburst = 0;
  logic        wready, wvalid = 0; logic [31:0] wdata = 0; logic [3:0] wstrb = 0; logic wlast = 0;
  logic        bready = 1, bvalid; logic [1:0] bresp; logic [3:0] bid;
  logic        arready, arvalid = 0; logic [31:0] araddr = 0; logic [3:0] arid = 0;
  logic [7:0]  arlen = 0; logic [2:0] arsize = 0; logic [1:0] arburst = 0;
  logic        rready, rvalid, rlast; logic [1:0] rresp; logic [31:0] rdata; logic [3:0] rid;
  logic        toggle_en = 0, tog = 0;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
  typedef struct packed { logic [1:0] resp; logic [3:0] id; } b_exp_t;
  r_exp_t r_q[$];
  b_exp_t b_q[$];
  int checks = 0, errors = 0, r_hs_cnt = 0;

  assign rready = toggle_en ? tog : 1'b1;

  axi_sram_slave #(.DEPTH(4096), .BASE(32'h8000_0000), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    if (toggle_en) tog = ~tog;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL timeout_%s: handshake never happened, expected it within the cycle budget", name);
  endtask

  // Scoreboard monitor: compares whatever the DUT presents, pops on handshake
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: got rdata 0x%08h rid %0d, expected no beat", rdata, rid);
      end else begin
        check("rdata", rdata, r_q[0].data);
        check("rresp", 32'(rresp), 32'(r_q[0].resp));
        check("rlast", 32'(rlast), 32'(r_q[0].last));
        check("rid",   32'(rid),   32'(r_q[0].id));
        if (rready) begin void'(r_q.pop_front()); r_hs_cnt++; end
      end
    end
    if (!rst && bvalid) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bresp %0d bid %0d, expected no response", bresp, bid);
      end else begin
        check("bresp", 32'(bresp), 32'(b_q[0].resp));
        check("bid",   32'(bid),   32'(b_q[0].id));
        if (bready) void'(b_q.pop_front());
      end
    end
  end

  task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    r_q.push_back('{d, resp, last, id});
  endtask
  task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
    b_q.push_back('{resp, id});
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] i, input logic [7:0] l,
                       input logic [1:0] b, input bit chk_lat);
    int n = 0;
    araddr = a; arid = i; arlen = l; arsize = 3'd2; arburst = b; arvalid = 1;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    if (!arready) timeout("ar");
    @(posedge clk); #1 arvalid = 0;
    if (chk_lat) begin
      n = 0;
      @(negedge clk);
      while (!rvalid && n < 50) begin n++; @(negedge clk); end
      check("rd_latency", 32'(n), 32'(RD_LAT));
    end
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] i, input logic [7:0] l, input logic [1:0] b);
    int n = 0;
    awaddr = a; awid = i; awlen = l; awsize = 3'd2; awburst = b; awvalid = 1;
    do begin @(negedge clk); n++; end while (!awready && n < 200);
    if (!awready) timeout("aw");
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1;
    do begin @(negedge clk); n++; end while (!wready && n < 200);
    if (!wready) timeout("w");
    @(posedge clk); #1 wvalid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(r_q.size() == 0 && b_q.size() == 0 && arready) && n < 1000);
    if (n >= 1000) timeout("idle");
    @(posedge clk); #1;
  endtask

  initial begin
    int start;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_arready", 32'(arready), 0); check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);   check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);   check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("idle_arready", 32'(arready), 1); check("idle_awready", 32'(awready), 1);
    @(posedge clk); #1;

    // Single write then read
    push_b(RESP_OKAY, 4'd3);
    do_aw(32'h8000_0010, 4'd3, 8'd0, BURST_INCR); do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_idle();
    push_r(32'hDEAD_BEEF, RESP_OKAY, 1'b1, 4'd5);
    do_ar(32'h8000_0010, 4'd5, 8'd0, BURST_INCR, 1'b1);
    wait_idle();

    // INCR burst, read back with rready toggling
    push_b(RESP_OKAY, 4'd1);
    do_aw(32'h8000_0100, 4'd1, 8'd3, BURST_INCR);
    do_w(32'h11, 4'hF, 0); do_w(32'h22, 4'hF, 0); do_w(32'h33, 4'hF, 0); do_w(32'h44, 4'hF, 1);
    wait_idle();
    push_r(32'h11, RESP_OKAY, 0, 4'd2); push_r(32'h22, RESP_OKAY, 0, 4'd2);
    push_r(32'h33, RESP_OKAY, 0, 4'd2); push_r(32'h44, RESP_OKAY, 1, 4'd2);
    toggle_en = 1;
    do_ar(32'h8000_0100, 4'd2, 8'd3, BURST_INCR, 1'b0);
    wait_idle();
    toggle_en = 0;

    // Byte strobes
    push_b(RESP_OKAY, 4'd4); push_b(RESP_OKAY, 4'd4);
    do_aw(32'h8000_0300, 4'd4, 8'd0, BURST_INCR); do_w(32'hFFFF_FFFF, 4'hF, 1);
    do_aw(32'h8000_0300, 4'd4, 8'd0, BURST_INCR); do_w(32'h0000_0000, 4'h5, 1);
    wait_idle();
    push_r(32'hFF00_FF00, RESP_OKAY, 1, 4'd4);
    do_ar(32'h8000_0300, 4'd4, 8'd0, BURST_INCR, 1'b0);
    wait_idle();

    // FIXED burst: both beats land on one word, last one wins
    push_b(RESP_OKAY, 4'd6);
    do_aw(32'h8000_0500, 4'd6, 8'd1, BURST_FIXED); do_w(32'h1, 4'hF, 0); do_w(32'h2, 4'hF, 1);
    wait_idle();
    push_r(32'h2, RESP_OKAY, 1, 4'd6);
    do_ar(32'h8000_0500, 4'd6, 8'd0, BURST_INCR, 1'b0);
    wait_idle();

    // Simultaneous AR/AW: read wins
    push_r(32'hDEAD_BEEF, RESP_OKAY, 1, 4'd10);
    push_b(RESP_OKAY, 4'd11);
    fork
      do_ar(32'h8000_0010, 4'd10, 8'd0, BURST_INCR, 1'b0);
      begin
        do_aw(32'h8000_0200, 4'd11, 8'd0, BURST_INCR);
        check("read_done_before_aw", 32'(r_q.size()), 0);
        do_w(32'hCAFE_F00D, 4'hF, 1);
      end
      begin
        @(negedge clk);
        check("sim_awready", 32'(awready), 0);
        check("sim_arready", 32'(arready), 1);
      end
    join
    wait_idle();
    push_r(32'hCAFE_F00D, RESP_OKAY, 1, 4'd12);
    do_ar(32'h8000_0200, 4'd12, 8'd0, BURST_INCR, 1'b0);
    wait_idle();

    // Decode errors at both window edges, last valid word is fine
    push_r(32'h0, RESP_DECERR, 1, 4'd6);
    do_ar(32'h7FFF_FFFC, 4'd6, 8'd0, BURST_INCR, 1'b0);
    push_r(32'h0, RESP_DECERR, 1, 4'd7);
    do_ar(32'h8000_4000, 4'd7, 8'd0, BURST_INCR, 1'b0);
    wait_idle();
    push_b(RESP_DECERR, 4'd8);
    do_aw(32'h7FFF_FFFC, 4'd8, 8'd0, BURST_INCR); do_w(32'h5, 4'hF, 1);
    push_b(RESP_OKAY, 4'd9);
    do_aw(32'h8000_3FFC, 4'd9, 8'd0, BURST_INCR); do_w(32'h1234_5678, 4'hF, 1);
    wait_idle();
    push_r(32'h1234_5678, RESP_OKAY, 1, 4'd9);
    do_ar(32'h8000_3FFC, 4'd9, 8'd0, BURST_INCR, 1'b0);
    wait_idle();

    // Early wlast: both beats still taken, SLVERR
    push_b(RESP_SLVERR, 4'd7);
    do_aw(32'h8000_0400, 4'd7, 8'd1, BURST_INCR); do_w(32'hAAAA_0000, 4'hF, 1); do_w(32'hBBBB_0001, 4'hF, 1);
    wait_idle();
    push_r(32'hAAAA_0000, RESP_OKAY, 0, 4'd7); push_r(32'hBBBB_0001, RESP_OKAY, 1, 4'd7);
    do_ar(32'h8000_0400, 4'd7, 8'd1, BURST_INCR, 1'b0);
    wait_idle();

    // Reset during beat 2 of an 8-beat read
    push_b(RESP_OKAY, 4'd8);
    do_aw(32'h8000_0600, 4'd8, 8'd7, BURST_INCR);
    for (int k = 0; k < 8; k++) do_w(32'hA0 + k, 4'hF, k == 7);
    wait_idle();
    for (int k = 0; k < 8; k++) push_r(32'hA0 + k, RESP_OKAY, k == 7, 4'd9);
    start = r_hs_cnt;
    do_ar(32'h8000_0600, 4'd9, 8'd7, BURST_INCR, 1'b0);
    for (int n = 0; n < 100 && (r_hs_cnt - start) < 2; n++) begin @(posedge clk); #3; end
    if ((r_hs_cnt - start) < 2) timeout("mid_burst");
    check("beat2_rvalid", 32'(rvalid), 1);
    rst = 1; #1;
    check("async_rvalid", 32'(rvalid), 0);
    check("async_rdata", rdata, 0);
    r_q.delete();
    @(negedge clk);
    check("rst_arready2", 32'(arready), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_arready", 32'(arready), 1);
    @(posedge clk); #1;
    push_r(32'hA0, RESP_OKAY, 1, 4'd4);
    do_ar(32'h8000_0600, 4'd4, 8'd0, BURST_INCR, 1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
